// File: rtl/arbiter_param.sv
// arbiter_param: N-way registered one-hot grant arbiter. It supports fixed-priority or
// round-robin selection and optional max-hold preemption, and reports a binary grant index.
module arbiter_param #(
   parameter int N        = 4,
   parameter int RR_MODE  = 0,
   parameter int MAX_HOLD = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [N-1:0]                        r,
   output logic [N-1:0]                        g,
   output logic                                gnt_valid,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id,
   output logic                                preempt
);

   localparam int IDW = (N > 1) ? $clog2(N) : 1;
   localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
   localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);

   typedef enum logic {IDLE, GRANT} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     g_q, g_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic             preempt_q, preempt_d;
   logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N-1:0]     mask_q, mask_d;

   logic [N-1:0]     eff_req;
   logic [IDW-1:0]   win;
   logic             holder_req;

   function automatic logic [IDW-1:0] pick_fixed(input logic [N-1:0] req);
      logic [IDW-1:0] w;
      w = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) w = IDW'(i);
      end
      return w;
   endfunction

   // Round-robin: the lowest request strictly above ptr wins, else wrap to the lowest overall.
   function automatic logic [IDW-1:0] pick_rr(input logic [N-1:0] req,
                                              input logic [IDW-1:0] ptr);
      logic [N-1:0] upper;
      for (int i = 0; i < N; i++) begin
         upper[i] = req[i] && (IDW'(i) > ptr);
      end
      return (|upper) ? pick_fixed(upper) : pick_fixed(req);
   endfunction

   // The just-preempted holder is masked for one arbitration unless it is the only requester.
   assign eff_req    = (|(r & ~mask_q)) ? (r & ~mask_q) : r;
   assign win        = (RR_MODE != 0) ? pick_rr(eff_req, rr_ptr_q) : pick_fixed(eff_req);
   assign holder_req = |(r & g_q);

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      gnt_id_d   = gnt_id_q;
      hold_cnt_d = hold_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      preempt_d  = 1'b0;
      mask_d     = '0;

      unique case (state_q)
         IDLE: begin
            if (|eff_req) begin
               state_d    = GRANT;
               g_d        = N'(1) << win;
               gnt_id_d   = win;
               hold_cnt_d = '0;
               rr_ptr_d   = win;
            end
         end
         GRANT: begin
            if (!holder_req) begin
               state_d    = IDLE;
               g_d        = '0;
               gnt_id_d   = '0;
               hold_cnt_d = '0;
            end else if (MAX_HOLD > 0 && hold_cnt_q == HOLD_LAST) begin
               state_d    = IDLE;
               g_d        = '0;
               gnt_id_d   = '0;
               hold_cnt_d = '0;
               preempt_d  = 1'b1;
               mask_d     = g_q;
            end else if (MAX_HOLD > 0) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            g_d     = '0;
         end
      endcase

      gnt_valid_d = |g_d;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         g_q         <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         preempt_q   <= 1'b0;
         hold_cnt_q  <= '0;
         rr_ptr_q    <= LAST_ID;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         preempt_q   <= preempt_d;
         hold_cnt_q  <= hold_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         mask_q      <= mask_d;
      end
   end

   assign g         = g_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign preempt   = preempt_q;

endmodule
